fetch_bundle_queue: RTL and testbench

FETCH_BUNDLE_QUEUE -- requirements
Module: fetch_bundle_queue

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/fetch_bundle_queue_storage.sv | 24 ++
 rtl/fetch_bundle_queue.sv | 95 +++++++++
 tb/tb_fetch_bundle_queue.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch bundle queue: bundle geometry, slot ordering
// and the packed storage entry layout.
package fetch_pkg;

  localparam int FBQ_DEPTH = 4;
  localparam int BUNDLE_W  = 64;
  localparam int SLOT_W    = 16;
  localparam int NUM_SLOTS = BUNDLE_W / SLOT_W;
  localparam int PC_W      = 16;
  localparam logic [SLOT_W-1:0] NOP_INST = 16'h0000;

  // Slot 0 occupies the most significant slice and maps to flag bit 3.
  localparam int SLOT0_BIT = NUM_SLOTS - 1;

  typedef struct packed {
    logic [PC_W-1:0]      pc;
    logic [BUNDLE_W-1:0]  inst;
    logic [NUM_SLOTS-1:0] tkn;
    logic [NUM_SLOTS-1:0] imjmp;
  } fbq_entry_t;

  localparam int ENTRY_W = $bits(fbq_entry_t);

  function automatic logic [NUM_SLOTS-1:0] slot_mask(input logic [BUNDLE_W-1:0] inst);
    logic [NUM_SLOTS-1:0] m;
    m = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      m[SLOT0_BIT - s] = (inst[BUNDLE_W - 1 - s*SLOT_W -: SLOT_W] != NOP_INST);
    end
    return m;
  endfunction

endpackage

// File: rtl/fetch_bundle_queue_storage.sv
// Bundle register file: one synchronous write port, one asynchronous read port.
// Contents are never cleared; the queue pointers alone define validity.
module fbq_storage
  import fetch_pkg::*;
#(
  parameter int DEPTH = FBQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  fbq_entry_t               wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output fbq_entry_t               rdata_o
);

  fbq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_bundle_queue.sv
// Fall-through circular queue between the branch handler and decode; all-NOP
// bundles are filtered out and a full queue stalls fetch.
module fetch_bundle_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FBQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [BUNDLE_W-1:0]      in_inst,
  input  logic [NUM_SLOTS-1:0]     in_tkn,
  input  logic [NUM_SLOTS-1:0]     in_imjmp,
  input  logic                     flush,
  input  logic                     deq_rdy,
  output logic                     out_valid,
  output logic [PC_W-1:0]          out_pc,
  output logic [BUNDLE_W-1:0]      out_inst,
  output logic [NUM_SLOTS-1:0]     out_tkn,
  output logic [NUM_SLOTS-1:0]     out_imjmp,
  output logic [NUM_SLOTS-1:0]     out_slot_vld,
  output logic                     stall_fetch,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a bundle moves in when enq is high at a rising edge and out when
  // deq is high; flush wins over both, and a full queue refuses new bundles even
  // if decode drains the head in the same cycle.
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic             full, enq, deq;
  fbq_entry_t       wr_entry, rd_entry;

  assign full = (count_q == CNT_W'(DEPTH));
  assign enq  = in_valid && !full && !flush && (in_inst != '0);
  assign deq  = (count_q != '0) && deq_rdy && !flush;

  assign wr_entry = '{pc: in_pc, inst: in_inst, tkn: in_tkn, imjmp: in_imjmp};

  fbq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .we_i    (enq),
    .waddr_i (tail_q),
    .wdata_i (wr_entry),
    .raddr_i (head_q),
    .rdata_o (rd_entry)
  );

  always_comb begin
    head_d    = head_q + PTR_W'(deq);
    tail_d    = tail_q + PTR_W'(enq);
    count_d   = count_q;
    last_pc_d = out_valid ? rd_entry.pc : last_pc_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      last_pc_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      last_pc_q <= last_pc_d;
    end
  end

  // When empty the stale head slot is masked; out_pc keeps showing the last head.
  assign out_valid    = (count_q != '0);
  assign out_pc       = out_valid ? rd_entry.pc : last_pc_q;
  assign out_inst     = out_valid ? rd_entry.inst : '0;
  assign out_tkn      = out_valid ? rd_entry.tkn : '0;
  assign out_imjmp    = out_valid ? rd_entry.imjmp : '0;
  assign out_slot_vld = out_valid ? slot_mask(rd_entry.inst) : '0;
  assign stall_fetch  = full;
  assign count        = count_q;

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Self-checking bench for fetch_bundle_queue: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_fetch_bundle_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_pc;
  logic [63:0] in_inst;
  logic [3:0]  in_tkn;
  logic [3:0]  in_imjmp;
  logic        flush;
  logic        deq_rdy;
  logic        out_valid;
  logic [15:0] out_pc;
  logic [63:0] out_inst;
  logic [3:0]  out_tkn;
  logic [3:0]  out_imjmp;
  logic [3:0]  out_slot_vld;
  logic        stall_fetch;
  logic [2:0]  count;

  fetch_bundle_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .in_tkn       (in_tkn),
    .in_imjmp     (in_imjmp),
    .flush        (flush),
    .deq_rdy      (deq_rdy),
    .out_valid    (out_valid),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_tkn      (out_tkn),
    .out_imjmp    (out_imjmp),
    .out_slot_vld (out_slot_vld),
    .stall_fetch  (stall_fetch),
    .count        (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  // Each entry: {pc[87:72], inst[71:8], tkn[7:4], imjmp[3:0]}
  logic [87:0] exp_q[$];
  logic [15:0] m_last_pc;
  int          tests;
  int          fails;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_slot_mask(input logic [63:0] inst);
    logic [3:0] m;
    logic [15:0] s;
    m = 4'b0;
    for (int k = 0; k < 4; k++) begin
      s = inst[63 - 16*k -: 16];
      if (s != 16'h0000) m[3 - k] = 1'b1;
    end
    return m;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_last_pc = 16'h0000;
  endtask

  task automatic model_step(input logic v, input logic [15:0] pc, input logic [63:0] inst,
                            input logic [3:0] tkn, input logic [3:0] imjmp,
                            input logic fl, input logic dr);
    bit room, take, give;
    room = (exp_q.size() < DEPTH);
    take = v && room && !fl && (inst != 64'h0);
    give = (exp_q.size() != 0) && dr && !fl;
    if (exp_q.size() != 0) m_last_pc = exp_q[0][87:72];
    if (fl) begin
      exp_q.delete();
    end else begin
      if (give) void'(exp_q.pop_front());
      if (take) exp_q.push_back({pc, inst, tkn, imjmp});
    end
  endtask

  task automatic check_model(input string tag);
    logic [87:0] h;
    bit          v;
    v = (exp_q.size() != 0);
    h = v ? exp_q[0] : 88'h0;
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".count"}, 64'(count), 64'(exp_q.size()));
    check({tag, ".stall"}, 64'(stall_fetch), 64'(exp_q.size() == DEPTH));
    check({tag, ".pc"}, 64'(out_pc), 64'(v ? h[87:72] : m_last_pc));
    check({tag, ".inst"}, out_inst, v ? h[71:8] : 64'h0);
    check({tag, ".tkn"}, 64'(out_tkn), 64'(v ? h[7:4] : 4'h0));
    check({tag, ".imjmp"}, 64'(out_imjmp), 64'(v ? h[3:0] : 4'h0));
    check({tag, ".slot_vld"}, 64'(out_slot_vld), 64'(v ? ref_slot_mask(h[71:8]) : 4'h0));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; applies inputs for the next rising edge and checks after it.
  task automatic drive_cycle(input string tag, input logic v, input logic [15:0] pc,
                             input logic [63:0] inst, input logic [3:0] tkn,
                             input logic [3:0] imjmp, input logic fl, input logic dr);
    in_valid = v;
    in_pc    = pc;
    in_inst  = inst;
    in_tkn   = tkn;
    in_imjmp = imjmp;
    flush    = fl;
    deq_rdy  = dr;
    model_step(v, pc, inst, tkn, imjmp, fl, dr);
    @(posedge clk);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_pc    = 16'h0;
    in_inst  = 64'h0;
    in_tkn   = 4'h0;
    in_imjmp = 4'h0;
    flush    = 1'b0;
    deq_rdy  = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [15:0] pc;
    logic [63:0] inst;
    logic [3:0]  tkn;
    logic        dr;
    logic [2:0]  e_cnt;
    logic        e_vld;
    logic        e_stall;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [15:0] pc;
    logic [63:0] inst;
    tests = 0;
    fails = 0;
    vecs[0]  = '{1'b1, 16'h0010, 64'h0001_0002_0003_0004, 4'b1000, 1'b0, 3'd1, 1'b1, 1'b0, 16'h0010};
    vecs[1]  = '{1'b1, 16'h0014, 64'h0005_0000_0006_0000, 4'b0100, 1'b0, 3'd2, 1'b1, 1'b0, 16'h0010};
    vecs[2]  = '{1'b1, 16'h0018, 64'h0000_0000_0000_0007, 4'b0010, 1'b0, 3'd3, 1'b1, 1'b0, 16'h0010};
    vecs[3]  = '{1'b1, 16'h001C, 64'hFFFF_0000_0008_0000, 4'b0001, 1'b0, 3'd4, 1'b1, 1'b1, 16'h0010};
    vecs[4]  = '{1'b1, 16'h0020, 64'h0009_0009_0009_0009, 4'b1111, 1'b0, 3'd4, 1'b1, 1'b1, 16'h0010};
    vecs[5]  = '{1'b0, 16'h0000, 64'h0,                   4'b0000, 1'b1, 3'd3, 1'b1, 1'b0, 16'h0014};
    vecs[6]  = '{1'b0, 16'h0000, 64'h0,                   4'b0000, 1'b1, 3'd2, 1'b1, 1'b0, 16'h0018};
    vecs[7]  = '{1'b0, 16'h0000, 64'h0,                   4'b0000, 1'b1, 3'd1, 1'b1, 1'b0, 16'h001C};
    vecs[8]  = '{1'b0, 16'h0000, 64'h0,                   4'b0000, 1'b1, 3'd0, 1'b0, 1'b0, 16'h001C};
    vecs[9]  = '{1'b1, 16'h0030, 64'h0,                   4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, 16'h001C};
    vecs[10] = '{1'b1, 16'h0040, 64'h1234_0000_0000_0000, 4'b0000, 1'b0, 3'd1, 1'b1, 1'b0, 16'h0040};

    // reset
    idle_inputs();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_model("reset");
    check("reset.count_zero", 64'(count), 64'd0);

    // fill, overflow attempt, drain, bubble filter
    for (int i = 0; i < 11; i++) begin
      drive_cycle($sformatf("vec%0d", i), vecs[i].v, vecs[i].pc, vecs[i].inst,
                  vecs[i].tkn, 4'b0000, 1'b0, vecs[i].dr);
      check($sformatf("vec%0d.t_count", i), 64'(count), 64'(vecs[i].e_cnt));
      check($sformatf("vec%0d.t_valid", i), 64'(out_valid), 64'(vecs[i].e_vld));
      check($sformatf("vec%0d.t_stall", i), 64'(stall_fetch), 64'(vecs[i].e_stall));
      check($sformatf("vec%0d.t_pc", i), 64'(out_pc), 64'(vecs[i].e_pc));
    end
    check("bubble.slot_vld", 64'(out_slot_vld), 64'(4'b1000));

    // flush with simultaneous enqueue and dequeue at count 3
    drive_cycle("flush_fill0", 1'b1, 16'h0044, 64'h0011_0000_0000_0000, 4'h0, 4'h0, 1'b0, 1'b0);
    drive_cycle("flush_fill1", 1'b1, 16'h0048, 64'h0000_0022_0000_0000, 4'h0, 4'h0, 1'b0, 1'b0);
    check("flush.pre_count", 64'(count), 64'd3);
    drive_cycle("flush", 1'b1, 16'h004C, 64'h0033_0033_0033_0033, 4'hF, 4'hF, 1'b1, 1'b1);
    check("flush.count", 64'(count), 64'd0);
    check("flush.valid", 64'(out_valid), 64'd0);
    check("flush.stall", 64'(stall_fetch), 64'd0);

    // pointer wrap: six enqueue/dequeue pairs at count 1
    drive_cycle("wrap_seed", 1'b1, 16'h0100, 64'h0100_0001_0000_0002, 4'b0100, 4'b0001, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      pc   = 16'h0100 + 16'(4 * i);
      inst = {pc, 16'h0001, 16'h0000, 16'(i)};
      drive_cycle($sformatf("wrap%0d", i), 1'b1, pc, inst, 4'b0100, 4'b0001, 1'b0, 1'b1);
      check($sformatf("wrap%0d.t_count", i), 64'(count), 64'd1);
      check($sformatf("wrap%0d.t_pc", i), 64'(out_pc), 64'(pc));
      check($sformatf("wrap%0d.t_tkn", i), 64'(out_tkn), 64'(4'b0100));
      check($sformatf("wrap%0d.t_imjmp", i), 64'(out_imjmp), 64'(4'b0001));
    end

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [63:0] ri;
      logic        rv, rf, rd;
      ri = 64'h0;
      if ($urandom_range(0, 9) != 0) begin
        for (int s = 0; s < 4; s++) begin
          if ($urandom_range(0, 9) >= 3) ri[16*s +: 16] = 16'($urandom_range(1, 16'hFFFF));
        end
      end
      rv = ($urandom_range(0, 3) != 0);
      rf = ($urandom_range(0, 29) == 0);
      rd = ($urandom_range(0, 2) == 0);
      drive_cycle($sformatf("rand%0d", i), rv, 16'($urandom), ri, 4'($urandom),
                  4'($urandom), rf, rd);
    end

    // asynchronous reset mid-operation with two entries held
    drive_cycle("rst_flush", 1'b0, 16'h0, 64'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    drive_cycle("rst_fill0", 1'b1, 16'h0200, 64'h0200_0200_0200_0200, 4'hA, 4'h5, 1'b0, 1'b0);
    drive_cycle("rst_fill1", 1'b1, 16'h0204, 64'h0204_0000_0000_0204, 4'h5, 4'hA, 1'b0, 1'b0);
    check("rst.pre_count", 64'(count), 64'd2);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.valid", 64'(out_valid), 64'd0);
    check("async_rst.count", 64'(count), 64'd0);
    check("async_rst.stall", 64'(stall_fetch), 64'd0);
    check("async_rst.pc", 64'(out_pc), 64'd0);
    check("async_rst.inst", out_inst, 64'd0);
    check("async_rst.tkn", 64'(out_tkn), 64'd0);
    check("async_rst.imjmp", 64'(out_imjmp), 64'd0);
    check("async_rst.slot_vld", 64'(out_slot_vld), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle("post_rst", 1'b1, 16'h0ABC, 64'h0000_0ABC_0000_0000, 4'b0010, 4'b0100, 1'b0, 1'b0);
    check("post_rst.pc", 64'(out_pc), 64'h0ABC);
    check("post_rst.slot_vld", 64'(out_slot_vld), 64'(4'b0100));
    drive_cycle("post_rst_deq", 1'b0, 16'h0, 64'h0, 4'h0, 4'h0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
